// File: rtl/output_grant_lock_if.sv
// Bus bundle between the switch inputs, the arbiter grant and one output port
// of output_grant_lock.
`default_nettype none

interface output_grant_lock_if #(
  parameter int IN_N   = 5,
  parameter int DATA_W = 8
);
  localparam int IW = (IN_N > 1) ? $clog2(IN_N) : 1;

  logic [IN_N-1:0]        req_i;
  logic [IN_N*DATA_W-1:0] data_i;
  logic [IN_N-1:0]        last_i;
  logic [IW-1:0]          grant_idx_i;
  logic [IN_N-1:0]        ready_o;
  logic                   valid_o;
  logic [DATA_W-1:0]      data_o;
  logic                   last_o;
  logic                   ready_i;
  logic                   locked_o;
  logic [IW-1:0]          owner_o;
  logic                   timeout_o;

  modport slave (
    input  req_i, data_i, last_i, grant_idx_i, ready_i,
    output ready_o, valid_o, data_o, last_o, locked_o, owner_o, timeout_o
  );

  modport master (
    output req_i, data_i, last_i, grant_idx_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, locked_o, owner_o, timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/output_grant_lock.sv
// output_grant_lock: wormhole lock of one switch output to the granted input, with
// registered valid/ready output stage. Optional idle-owner watchdog: OUT_LOCK_TIMEOUT_EN.
`default_nettype none

module output_grant_lock #(
  parameter int IN_N        = 5,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output_grant_lock_if.slave  bus
);
  localparam int c_IW = (IN_N > 1) ? $clog2(IN_N) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_IW-1:0]   r_owner;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  logic              w_grant_ok;
  logic              w_req_own;
  logic              w_last_own;
  logic              w_rdy_own;
  logic              w_accept;
  logic              w_expired;

  // Out-of-range grant indices are rejected before the request bit is trusted.
  assign w_grant_ok = (|bus.req_i) && (32'(bus.grant_idx_i) < IN_N)
                      && bus.req_i[bus.grant_idx_i];
  assign w_req_own  = bus.req_i[r_owner];
  assign w_last_own = bus.last_i[r_owner];
  assign w_rdy_own  = (r_state == S_LOCKED) && (!r_valid || bus.ready_i);
  assign w_accept   = w_req_own && w_rdy_own;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_ok) w_next = S_LOCKED;
      S_LOCKED: if ((w_accept && w_last_own) || w_expired) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_grant_ok) r_owner <= bus.grant_idx_i;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= bus.data_i[r_owner*DATA_W +: DATA_W];
        r_last  <= w_last_own;
      end else if (bus.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef OUT_LOCK_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT_CYC + 1);

  logic [c_CW-1:0] r_cnt;
  logic            r_timeout;

  assign w_expired = (r_state == S_LOCKED) && (r_cnt == c_CW'(TIMEOUT_CYC));

  // The pulse is raised on the edge the count reaches the limit; release follows one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state != S_LOCKED || w_accept || w_expired) begin
        r_cnt <= '0;
      end else if (!w_req_own) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_CW'(TIMEOUT_CYC - 1)) r_timeout <= 1'b1;
      end
    end
  end

  assign bus.timeout_o = r_timeout;
`else
  assign w_expired     = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    bus.ready_o = '0;
    for (int k = 0; k < IN_N; k++) begin
      bus.ready_o[k] = w_rdy_own && (32'(r_owner) == k);
    end
  end

  assign bus.valid_o  = r_valid;
  assign bus.data_o   = r_data;
  assign bus.last_o   = r_last;
  assign bus.locked_o = (r_state == S_LOCKED);
  assign bus.owner_o  = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_output_grant_lock.sv
// Directed table-driven bench for output_grant_lock (IN_N=5, DATA_W=8), plus hand
// sequences for reset mid-packet and a stalled owner.
`default_nettype none

module tb_output_grant_lock;
  localparam int N  = 5;
  localparam int DW = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  output_grant_lock_if #(.IN_N(N), .DATA_W(DW)) bus ();

  output_grant_lock #(.IN_N(N), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0] req;
    logic [2:0] gnt;
    logic [2:0] ds;
    logic [7:0] d;
    logic       lst;
    logic       rdy;
    logic [4:0] e_ready;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_locked;
    logic [2:0] e_owner;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Slot ds carries the payload; all other slots carry 0xEE with last=1 so a wrong owner is visible.
  task automatic drive(input logic [4:0] req, input logic [2:0] gnt, input logic [2:0] ds,
                       input logic [7:0] d, input logic lst, input logic rdy);
    logic [N*DW-1:0] dat;
    logic [N-1:0]    lf;
    dat = {N{8'hEE}};
    dat[ds*DW +: DW] = d;
    lf = '1;
    lf[ds] = lst;
    bus.req_i       = req;
    bus.grant_idx_i = gnt;
    bus.data_i      = dat;
    bus.last_i      = lf;
    bus.ready_i     = rdy;
  endtask

  function automatic vec_t mk(logic [4:0] req, logic [2:0] gnt, logic [2:0] ds, logic [7:0] d,
                              logic lst, logic rdy, logic [4:0] er, logic ev, logic [7:0] ed,
                              logic el, logic elk, logic [2:0] eo);
    vec_t v;
    v.req = req; v.gnt = gnt; v.ds = ds; v.d = d; v.lst = lst; v.rdy = rdy;
    v.e_ready = er; v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_locked = elk; v.e_owner = eo;
    return v;
  endfunction

  vec_t tbl[26];

  initial begin
    //             req       gnt ds d      lst rdy  ready     v  data   l  lk o
    tbl[0]  = mk(5'b00100, 2, 2, 8'h11, 0, 1, 5'b00000, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(5'b00100, 2, 2, 8'h11, 0, 1, 5'b00100, 0, 8'h00, 0, 1, 2);
    tbl[2]  = mk(5'b00100, 2, 2, 8'h22, 0, 1, 5'b00100, 1, 8'h11, 0, 1, 2);
    tbl[3]  = mk(5'b00100, 2, 2, 8'h33, 1, 1, 5'b00100, 1, 8'h22, 0, 1, 2);
    tbl[4]  = mk(5'b00000, 0, 0, 8'h00, 0, 1, 5'b00000, 1, 8'h33, 1, 0, 2);
    tbl[5]  = mk(5'b00000, 0, 0, 8'h00, 0, 1, 5'b00000, 0, 8'h33, 1, 0, 2);
    tbl[6]  = mk(5'b00001, 6, 0, 8'h44, 0, 1, 5'b00000, 0, 8'h33, 1, 0, 2);
    tbl[7]  = mk(5'b00001, 3, 0, 8'h44, 0, 1, 5'b00000, 0, 8'h33, 1, 0, 2);
    tbl[8]  = mk(5'b00001, 0, 0, 8'hA5, 0, 1, 5'b00000, 0, 8'h33, 1, 0, 2);
    tbl[9]  = mk(5'b00001, 0, 0, 8'hA5, 0, 1, 5'b00001, 0, 8'h33, 1, 1, 0);
    tbl[10] = mk(5'b00001, 0, 0, 8'hB6, 0, 0, 5'b00000, 1, 8'hA5, 0, 1, 0);
    tbl[11] = mk(5'b00001, 0, 0, 8'hB6, 0, 0, 5'b00000, 1, 8'hA5, 0, 1, 0);
    tbl[12] = mk(5'b00001, 0, 0, 8'hB6, 0, 0, 5'b00000, 1, 8'hA5, 0, 1, 0);
    tbl[13] = mk(5'b00001, 0, 0, 8'hB6, 1, 1, 5'b00001, 1, 8'hA5, 0, 1, 0);
    tbl[14] = mk(5'b00000, 0, 0, 8'h00, 0, 1, 5'b00000, 1, 8'hB6, 1, 0, 0);
    tbl[15] = mk(5'b00000, 0, 0, 8'h00, 0, 1, 5'b00000, 0, 8'hB6, 1, 0, 0);
    tbl[16] = mk(5'b00010, 1, 1, 8'hC1, 0, 1, 5'b00000, 0, 8'hB6, 1, 0, 0);
    tbl[17] = mk(5'b00010, 1, 1, 8'hC1, 0, 1, 5'b00010, 0, 8'hB6, 1, 1, 1);
    tbl[18] = mk(5'b00011, 0, 1, 8'hC2, 0, 1, 5'b00010, 1, 8'hC1, 0, 1, 1);
    tbl[19] = mk(5'b00011, 0, 1, 8'hC3, 0, 1, 5'b00010, 1, 8'hC2, 0, 1, 1);
    tbl[20] = mk(5'b00001, 0, 1, 8'hC4, 1, 1, 5'b00010, 1, 8'hC3, 0, 1, 1);
    tbl[21] = mk(5'b00011, 0, 1, 8'hC4, 1, 1, 5'b00010, 0, 8'hC3, 0, 1, 1);
    tbl[22] = mk(5'b00011, 0, 1, 8'hC4, 1, 1, 5'b00000, 1, 8'hC4, 1, 0, 1);
    tbl[23] = mk(5'b00011, 0, 0, 8'hD0, 1, 1, 5'b00001, 0, 8'hC4, 1, 1, 0);
    tbl[24] = mk(5'b00000, 0, 0, 8'h00, 0, 1, 5'b00000, 1, 8'hD0, 1, 0, 0);
    tbl[25] = mk(5'b00000, 0, 0, 8'h00, 0, 1, 5'b00000, 0, 8'hD0, 1, 0, 0);

    // Reset state with activity on the inputs.
    drive(5'b00100, 2, 2, 8'h5A, 1, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    chk("rst_ready",  32'(bus.ready_o),   0);
    chk("rst_valid",  32'(bus.valid_o),   0);
    chk("rst_data",   32'(bus.data_o),    0);
    chk("rst_last",   32'(bus.last_o),    0);
    chk("rst_locked", 32'(bus.locked_o),  0);
    chk("rst_owner",  32'(bus.owner_o),   0);
    chk("rst_tmo",    32'(bus.timeout_o), 0);
    drive(5'b00000, 0, 0, 8'h00, 0, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].ds, tbl[i].d, tbl[i].lst, tbl[i].rdy);
      #2;
      chk($sformatf("v%0d_ready", i),  32'(bus.ready_o),   32'(tbl[i].e_ready));
      chk($sformatf("v%0d_valid", i),  32'(bus.valid_o),   32'(tbl[i].e_valid));
      chk($sformatf("v%0d_data", i),   32'(bus.data_o),    32'(tbl[i].e_data));
      chk($sformatf("v%0d_last", i),   32'(bus.last_o),    32'(tbl[i].e_last));
      chk($sformatf("v%0d_locked", i), 32'(bus.locked_o),  32'(tbl[i].e_locked));
      chk($sformatf("v%0d_owner", i),  32'(bus.owner_o),   32'(tbl[i].e_owner));
      chk($sformatf("v%0d_tmo", i),    32'(bus.timeout_o), 0);
      @(negedge clk_i);
    end

    // Reset asserted between edges while flit 2 of a packet from input 3 is offered.
    drive(5'b01000, 3, 3, 8'hE1, 0, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    drive(5'b01000, 3, 3, 8'hE2, 0, 1);
    #2;
    chk("mid_valid_pre", 32'(bus.valid_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_valid",  32'(bus.valid_o),  0);
    chk("mid_locked", 32'(bus.locked_o), 0);
    chk("mid_ready",  32'(bus.ready_o),  0);
    chk("mid_data",   32'(bus.data_o),   0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(5'b10000, 4, 4, 8'hF1, 1, 1);
    #2;
    chk("post_locked0", 32'(bus.locked_o), 0);
    @(negedge clk_i);
    #2;
    chk("post_locked1", 32'(bus.locked_o), 1);
    chk("post_owner",   32'(bus.owner_o),  4);
    chk("post_ready",   32'(bus.ready_o),  32'(5'b10000));
    @(negedge clk_i);
    drive(5'b00000, 0, 0, 8'h00, 0, 1);
    #2;
    chk("post_valid",  32'(bus.valid_o),  1);
    chk("post_data",   32'(bus.data_o),   32'h F1);
    chk("post_last",   32'(bus.last_o),   1);
    chk("post_unlock", 32'(bus.locked_o), 0);
    @(negedge clk_i);

    // Owner stalls after its head flit.
    drive(5'b00100, 2, 2, 8'h77, 0, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    drive(5'b00000, 2, 2, 8'h00, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      #2;
`ifdef OUT_LOCK_TIMEOUT_EN
      chk($sformatf("stall%0d_tmo", k),    32'(bus.timeout_o), (k == 17) ? 1 : 0);
      chk($sformatf("stall%0d_locked", k), 32'(bus.locked_o),  (k <= 17) ? 1 : 0);
`else
      chk($sformatf("stall%0d_tmo", k),    32'(bus.timeout_o), 0);
      chk($sformatf("stall%0d_locked", k), 32'(bus.locked_o),  1);
`endif
      @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
